// File: rtl/set_compare_seq_if.sv
// Start/done handshake and result bundle for the multi-cycle set/compare unit.
// The master drives the request; the slave (the comparator) returns status and the held result.
interface set_compare_seq_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic         result;
  logic         eq_flag;
  logic         gt_flag;
  logic         lt_flag;

  modport master (
    output start, op, a, b,
    input  busy, done, result, eq_flag, gt_flag, lt_flag
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, eq_flag, gt_flag, lt_flag
  );
endinterface

// File: rtl/set_compare_seq.sv
// Multi-cycle signed set/compare: MSB-first scan of K bits per clock, fixed N/K-cycle latency,
// producing a 1-bit set value and sticky eq/gt/lt flags behind a start/done handshake.
module set_compare_seq #(
  parameter int N = 32,
  parameter int K = 1
) (
  input  logic             clk,
  input  logic             rst,
  set_compare_seq_if.slave bus
);
  localparam int NCH   = N / K;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(NCH - 1);
  localparam logic [N-1:0]     MSB_MASK = {1'b1, {(N-1){1'b0}}};

  if (N % K != 0) begin : g_bad_k
    $error("set_compare_seq: N must be a multiple of K");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             decided_q, decided_d, greater_q, greater_d;
  logic             busy_q, busy_d, done_q, done_d, result_q, result_d;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;

  logic [K-1:0]     chunk_a, chunk_b;
  logic             dec_n, gr_n;

  function automatic logic set_value(input logic [2:0] op, input logic eq, input logic gt,
                                     input logic lt);
    case (op)
      3'd0:    set_value = eq;
      3'd1:    set_value = gt;
      3'd2:    set_value = gt | eq;
      3'd3:    set_value = lt;
      3'd4:    set_value = lt | eq;
      default: set_value = 1'b0;
    endcase
  endfunction

  // Operands shift left each scan cycle, so the current chunk is always the top K bits.
  assign chunk_a = a_q[N-1 -: K];
  assign chunk_b = b_q[N-1 -: K];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    greater_d = greater_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;

    dec_n = decided_q;
    gr_n  = greater_q;
    if (!decided_q && (chunk_a != chunk_b)) begin
      dec_n = 1'b1;
      gr_n  = (chunk_a > chunk_b);
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          // Inverting the sign bit turns signed order into plain unsigned order.
          a_d       = bus.a ^ MSB_MASK;
          b_d       = bus.b ^ MSB_MASK;
          op_d      = bus.op;
          cnt_d     = '0;
          decided_d = 1'b0;
          greater_d = 1'b0;
          busy_d    = 1'b1;
          result_d  = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        decided_d = dec_n;
        greater_d = gr_n;
        a_d       = a_q << K;
        b_d       = b_q << K;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          busy_d   = 1'b0;
          done_d   = 1'b1;
          eq_d     = ~dec_n;
          gt_d     = dec_n & gr_n;
          lt_d     = dec_n & ~gr_n;
          result_d = set_value(op_q, ~dec_n, dec_n & gr_n, dec_n & ~gr_n);
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      greater_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      greater_q <= greater_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.eq_flag = eq_q;
  assign bus.gt_flag = gt_q;
  assign bus.lt_flag = lt_q;
endmodule

// File: tb/tb_set_compare_seq.sv
// Bench for set_compare_seq: three instances (K=1, 4, 8) share one clock/reset, driven by
// directed vectors, hand-written handshake/reset sequences and random operands vs a signed model.
module tb_set_compare_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  set_compare_seq_if #(.N(32)) if1 ();
  set_compare_seq_if #(.N(32)) if4 ();
  set_compare_seq_if #(.N(32)) if8 ();

  set_compare_seq #(.N(32), .K(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  set_compare_seq #(.N(32), .K(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  set_compare_seq #(.N(32), .K(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  logic        st[3];
  logic [2:0]  opr[3];
  logic [31:0] ar[3], br[3];
  logic        busy_w[3], done_w[3], res_w[3], eq_w[3], gt_w[3], lt_w[3];

  assign if1.start = st[0];  assign if1.op = opr[0];  assign if1.a = ar[0];  assign if1.b = br[0];
  assign if4.start = st[1];  assign if4.op = opr[1];  assign if4.a = ar[1];  assign if4.b = br[1];
  assign if8.start = st[2];  assign if8.op = opr[2];  assign if8.a = ar[2];  assign if8.b = br[2];

  assign busy_w[0] = if1.busy; assign done_w[0] = if1.done; assign res_w[0] = if1.result;
  assign eq_w[0] = if1.eq_flag; assign gt_w[0] = if1.gt_flag; assign lt_w[0] = if1.lt_flag;
  assign busy_w[1] = if4.busy; assign done_w[1] = if4.done; assign res_w[1] = if4.result;
  assign eq_w[1] = if4.eq_flag; assign gt_w[1] = if4.gt_flag; assign lt_w[1] = if4.lt_flag;
  assign busy_w[2] = if8.busy; assign done_w[2] = if8.done; assign res_w[2] = if8.result;
  assign eq_w[2] = if8.eq_flag; assign gt_w[2] = if8.gt_flag; assign lt_w[2] = if8.lt_flag;

  int checks = 0;
  int failures = 0;
  int exp_lat[3] = '{33, 9, 5};

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        r, eq, gt, lt;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: signed comparison straight from the operand values.
  function automatic logic [3:0] model(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic eq, gt, lt, r;
    eq = (a == b);
    gt = ($signed(a) > $signed(b));
    lt = ($signed(a) < $signed(b));
    case (op)
      3'd0: r = eq;
      3'd1: r = gt;
      3'd2: r = gt | eq;
      3'd3: r = lt;
      3'd4: r = lt | eq;
      default: r = 1'b0;
    endcase
    return {r, eq, gt, lt};
  endfunction

  // Launch one op on instance d and wait (bounded) for done; lat counts cycles from start.
  task automatic do_op(input int d, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int lat);
    @(negedge clk);
    st[d] = 1'b1; opr[d] = op; ar[d] = a; br[d] = b;
    @(negedge clk);
    st[d] = 1'b0; opr[d] = 3'($urandom); ar[d] = $urandom; br[d] = $urandom;
    chk("busy_after_start", {31'b0, busy_w[d]}, 32'd1);
    lat = 1;
    while (!done_w[d] && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_out(input int d, input string name, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b, input int lat);
    logic [3:0] m;
    m = model(op, a, b);
    chk({name, "_latency"}, lat, exp_lat[d]);
    chk({name, "_result"}, {31'b0, res_w[d]}, {31'b0, m[3]});
    chk({name, "_eq"}, {31'b0, eq_w[d]}, {31'b0, m[2]});
    chk({name, "_gt"}, {31'b0, gt_w[d]}, {31'b0, m[1]});
    chk({name, "_lt"}, {31'b0, lt_w[d]}, {31'b0, m[0]});
    chk({name, "_onehot"}, $countones({eq_w[d], gt_w[d], lt_w[d]}), 32'd1);
  endtask

  task automatic rand_op(input int d);
    logic [2:0]  op;
    logic [31:0] a, b;
    int lat;
    op = 3'($urandom);
    a  = $urandom;
    case ($urandom_range(0, 3))
      0: b = $urandom;
      1: b = a;
      2: b = a ^ (32'd1 << $urandom_range(0, 31));
      default: b = {~a[31], $urandom_range(0, 32'h7fffffff)};
    endcase
    do_op(d, op, a, b, lat);
    check_out(d, "random", op, a, b, lat);
  endtask

  initial begin
    int lat;
    int cyc;
    logic seen;
    vecs[0]  = '{3'd3, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{3'd1, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{3'd0, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd4, 32'h12345678, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd3, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd6, 32'h12345678, 32'h12345678, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd2, 32'h00000002, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'd4, 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{3'd7, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};

    for (int d = 0; d < 3; d++) begin
      st[d] = 1'b0; opr[d] = '0; ar[d] = '0; br[d] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", {31'b0, busy_w[d]}, 32'd0);
      chk("reset_done", {31'b0, done_w[d]}, 32'd0);
      chk("reset_flags", {28'b0, res_w[d], eq_w[d], gt_w[d], lt_w[d]}, 32'd0);
    end
    rst = 1'b0;

    // Directed table on the K=1 instance.
    for (int i = 0; i < 12; i++) begin
      do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk("vec_latency", lat, 33);
      chk("vec_result", {31'b0, res_w[0]}, {31'b0, vecs[i].r});
      chk("vec_flags", {29'b0, eq_w[0], gt_w[0], lt_w[0]},
          {29'b0, vecs[i].eq, vecs[i].gt, vecs[i].lt});
    end

    // Done is a single pulse; result and flags hold afterwards.
    repeat (3) @(negedge clk);
    chk("hold_done_low", {31'b0, done_w[0]}, 32'd0);
    chk("hold_flags", {28'b0, res_w[0], eq_w[0], gt_w[0], lt_w[0]}, 32'b0010);

    // LSB-only difference at K=4 and K=8.
    do_op(1, 3'd2, 32'h2, 32'h1, lat);
    check_out(1, "k4_lsb", 3'd2, 32'h2, 32'h1, lat);
    do_op(2, 3'd2, 32'h2, 32'h1, lat);
    check_out(2, "k8_lsb", 3'd2, 32'h2, 32'h1, lat);

    // Start pulsed mid-scan with different operands must be ignored.
    @(negedge clk);
    st[0] = 1'b1; opr[0] = 3'd1; ar[0] = 32'd1; br[0] = 32'd2;
    @(negedge clk);
    st[0] = 1'b0;
    lat = 1;
    repeat (4) begin @(negedge clk); lat++; end
    st[0] = 1'b1; opr[0] = 3'd1; ar[0] = 32'd9; br[0] = 32'd2;
    @(negedge clk); lat++;
    st[0] = 1'b0;
    while (!done_w[0] && lat < 60) begin @(negedge clk); lat++; end
    check_out(0, "ignore_start", 3'd1, 32'd1, 32'd2, lat);

    // Back-to-back: start in the DONE cycle is accepted with no gap.
    do_op(0, 3'd1, 32'd5, 32'd3, lat);
    check_out(0, "b2b_first", 3'd1, 32'd5, 32'd3, lat);
    st[0] = 1'b1; opr[0] = 3'd3; ar[0] = 32'hFFFFFFF0; br[0] = 32'd3;
    @(negedge clk);
    st[0] = 1'b0;
    chk("b2b_busy", {31'b0, busy_w[0]}, 32'd1);
    chk("b2b_cleared", {28'b0, res_w[0], eq_w[0], gt_w[0], lt_w[0]}, 32'd0);
    lat = 1;
    while (!done_w[0] && lat < 60) begin @(negedge clk); lat++; end
    check_out(0, "b2b_second", 3'd3, 32'hFFFFFFF0, 32'd3, lat);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    st[0] = 1'b1; opr[0] = 3'd0; ar[0] = 32'd7; br[0] = 32'd7;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'b0, busy_w[0]}, 32'd0);
    chk("async_rst_outs", {28'b0, res_w[0], eq_w[0], gt_w[0], lt_w[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) seen = 1'b1;
    end
    chk("no_done_after_rst", {31'b0, seen}, 32'd0);
    do_op(0, 3'd2, 32'h2, 32'h1, lat);
    check_out(0, "after_rst", 3'd2, 32'h2, 32'h1, lat);

    // Random operands on all three widths in parallel.
    for (int n = 0; n < 1000; n++) begin
      fork
        rand_op(0);
        rand_op(1);
        rand_op(2);
      join
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
